// File: rtl/major_state_seq_pkg.sv
// Shared constants for the major-state sequencer: major codes, phase/wait widths, opcode patterns.
package major_state_seq_pkg;

    localparam int PHASE_W = 2;
    localparam int WCNT_W  = 3;

    typedef enum logic [2:0] {
        MAJ_F = 3'd0,
        MAJ_D = 3'd1,
        MAJ_E = 3'd2,
        MAJ_B = 3'd3,
        MAJ_H = 3'd4
    } major_e;

    localparam logic [3:0]  OP_JMP   = 4'b1010;
    localparam logic [3:0]  OP_JMPI  = 4'b1011;
    localparam logic [5:0]  HLT_PAT  = 6'b111110;
    localparam logic [11:0] IOT_6002 = 12'o6002;

endpackage

// File: rtl/major_state_seq_if.sv
// Panel/CPU-side signal bundle of the major-state sequencer; master drives controls, slave is the sequencer.
interface major_state_seq_if;

    logic                                    halt;
    logic                                    single_step;
    logic                                    single_instr;
    logic                                    cont;
    logic                                    int_req;
    logic                                    int_ena;
    logic                                    int_inh;
    logic                                    UF;
    logic                                    trigger;
    logic                                    brk_req;
    logic [0:11]                             instruction;
    logic [2:0]                              major;
    logic [major_state_seq_pkg::PHASE_W-1:0] phase;
    logic                                    in_wait;
    logic                                    int_in_prog;
    logic                                    brk_ack;

    modport master (
        output halt, single_step, single_instr, cont, int_req, int_ena, int_inh, UF,
               trigger, brk_req, instruction,
        input  major, phase, in_wait, int_in_prog, brk_ack
    );

    modport slave (
        input  halt, single_step, single_instr, cont, int_req, int_ena, int_inh, UF,
               trigger, brk_req, instruction,
        output major, phase, in_wait, int_in_prog, brk_ack
    );

endinterface

// File: rtl/major_state_seq_phase_timer.sv
// Phase counter for one major cycle: phase 0, optional wait states (down-counter), phases 1..3.
module phase_timer
    import major_state_seq_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               restart_i,
    input  logic               no_wait_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               in_wait_o
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

    logic [PHASE_W-1:0] phase_q;
    logic               in_wait_q;
    logic [WCNT_W-1:0]  wcnt_q;

    always_ff @(posedge clk) begin
        if (reset || restart_i) begin
            phase_q   <= '0;
            in_wait_q <= 1'b0;
            wcnt_q    <= '0;
        end else if (in_wait_q) begin
            if (wcnt_q == '0) begin
                in_wait_q <= 1'b0;
                phase_q   <= PHASE_W'(1);
            end else begin
                wcnt_q <= wcnt_q - 1'b1;
            end
        end else if (phase_q == '0) begin
            // the wait count is loaded on the clock that releases the stall
            if (!stall_i) begin
                if (no_wait_i || WAIT_STATES == 0) begin
                    phase_q <= PHASE_W'(1);
                end else begin
                    in_wait_q <= 1'b1;
                    wcnt_q    <= WAIT_LOAD;
                end
            end
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

    assign phase_o   = phase_q;
    assign in_wait_o = in_wait_q;

endmodule

// File: rtl/major_state_seq.sv
// Major-state sequencer: F/D/E/B/H cycles, next-major decision at phase 3, data-break and halt panel.
//   major | meaning
//   F     | instruction fetch
//   D     | defer (indirect address)
//   E     | execute
//   B     | data break (DMA), returns to the saved destination
//   H     | halted; panel phases H0, HW(H1), optional H2/H3 on trigger
module major_state_seq
    import major_state_seq_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter bit BRK_ENABLE  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    major_state_seq_if.slave  seq_if
);

    major_e             major_q, dest_d, sav_dest_q;
    logic               iip_q, iip_set_d, sav_iip_q, brk_ack_q;
    logic [PHASE_W-1:0] phase;
    logic               in_wait, stall, restart, int_cond;

    assign int_cond = seq_if.int_req && seq_if.int_ena && !seq_if.int_inh;

    assign stall = ((major_q inside {MAJ_F, MAJ_D, MAJ_E}) && seq_if.single_step && !seq_if.cont)
                || ((major_q == MAJ_F) && seq_if.single_instr && !seq_if.cont);

    assign restart = ((major_q == MAJ_H) && (phase == PHASE_W'(1)) && (seq_if.cont || !seq_if.trigger))
                  || !(major_q inside {MAJ_F, MAJ_D, MAJ_E, MAJ_B, MAJ_H});

    phase_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .stall_i   (stall),
        .restart_i (restart),
        .no_wait_i (major_q == MAJ_H),
        .phase_o   (phase),
        .in_wait_o (in_wait)
    );

    always_comb begin
        dest_d    = MAJ_F;
        iip_set_d = 1'b0;
        case (major_q)
            MAJ_F: begin
                if (seq_if.instruction[0:1] == 2'b11 || seq_if.instruction[0:3] == OP_JMP) begin
                    if (seq_if.halt) begin
                        dest_d = MAJ_H;
                    end else if ({seq_if.instruction[0:3], seq_if.instruction[10:11]} == HLT_PAT && !seq_if.UF) begin
                        dest_d = MAJ_H;
                    end else if (int_cond && seq_if.instruction != IOT_6002) begin
                        dest_d    = MAJ_E;
                        iip_set_d = 1'b1;
                    end
                end else begin
                    dest_d = seq_if.instruction[3] ? MAJ_D : MAJ_E;
                end
            end
            MAJ_D: begin
                if (seq_if.instruction[0:3] == OP_JMPI) begin
                    if (int_cond) begin
                        dest_d    = MAJ_E;
                        iip_set_d = 1'b1;
                    end else if (seq_if.halt) begin
                        dest_d = MAJ_H;
                    end
                end else begin
                    dest_d = MAJ_E;
                end
            end
            MAJ_E: begin
                if (seq_if.halt) begin
                    dest_d = MAJ_H;
                end else if (!iip_q && int_cond) begin
                    dest_d    = MAJ_E;
                    iip_set_d = 1'b1;
                end
            end
            MAJ_B: begin
                dest_d    = sav_dest_q;
                iip_set_d = sav_iip_q;
            end
            default: dest_d = MAJ_H;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            major_q    <= MAJ_H;
            iip_q      <= 1'b0;
            brk_ack_q  <= 1'b0;
            sav_dest_q <= MAJ_F;
            sav_iip_q  <= 1'b0;
        end else begin
            brk_ack_q <= BRK_ENABLE && (major_q == MAJ_B) && (phase == PHASE_W'(2));
            case (major_q)
                MAJ_H: begin
                    if (phase == PHASE_W'(1) && seq_if.cont) begin
                        major_q <= MAJ_F;
                        iip_q   <= 1'b0;
                    end
                end
                MAJ_F, MAJ_D, MAJ_E, MAJ_B: begin
                    if (phase == PHASE_W'(3)) begin
                        // a back-to-back break keeps the destination saved by the first one
                        if (BRK_ENABLE && seq_if.brk_req) begin
                            major_q <= MAJ_B;
                            if (major_q != MAJ_B) begin
                                sav_dest_q <= dest_d;
                                sav_iip_q  <= iip_set_d;
                            end
                        end else begin
                            major_q <= dest_d;
                            if (dest_d == MAJ_F) begin
                                iip_q <= 1'b0;
                            end else if (iip_set_d) begin
                                iip_q <= 1'b1;
                            end
                        end
                    end
                end
                default: major_q <= MAJ_H;
            endcase
        end
    end

    assign seq_if.major       = major_q;
    assign seq_if.phase       = phase;
    assign seq_if.in_wait     = in_wait;
    assign seq_if.int_in_prog = iip_q;
    assign seq_if.brk_ack     = brk_ack_q;

endmodule

// File: tb/tb_major_state_seq.sv
// Bench for major_state_seq: directed scenarios plus random major cycles against a per-cycle reference model.
module tb_major_state_seq;

    localparam int WS     = 2;
    localparam bit BRK_EN = 1'b1;
    localparam int MF = 0, MD = 1, ME = 2, MB = 3, MH = 4;

    logic clk = 1'b0;
    logic reset;

    major_state_seq_if bus ();

    major_state_seq #(.WAIT_STATES(WS), .BRK_ENABLE(BRK_EN)) dut (
        .clk    (clk),
        .reset  (reset),
        .seq_if (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state, advanced once per major cycle
    int m_maj;
    bit m_iip;
    int m_pdest;
    bit m_pset;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h (maj/ph/w/iip/ack) expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pk(input int m, input int ph, input bit w, input bit iip, input bit ack);
        return {3'(m), 2'(ph), w, iip, ack};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.major, bus.phase, bus.in_wait, bus.int_in_prog, bus.brk_ack};
    endfunction

    function automatic bit rb(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    task automatic model_reset();
        m_maj   = MH;
        m_iip   = 1'b0;
        m_pdest = MF;
        m_pset  = 1'b0;
    endtask

    // next major from the decode rules, using octal ranges of the instruction word
    function automatic void ref_decide(input int m, input logic [11:0] ins, input bit hlt, input bit uf,
                                       input bit intc, input bit iip, output int d, output bit s);
        int v;
        v = int'(ins);
        s = 1'b0;
        d = MF;
        if (m == MF) begin
            if (v >= 'o6000 || (v >= 'o5000 && v < 'o5400)) begin
                if (hlt) d = MH;
                else if (v >= 'o7400 && (v % 4) == 2 && !uf) d = MH;
                else if (intc && v != 'o6002) begin d = ME; s = 1'b1; end
                else d = MF;
            end else begin
                d = ((v / 'o400) % 2 == 1) ? MD : ME;
            end
        end else if (m == MD) begin
            if (v >= 'o5400 && v < 'o6000) begin
                if (intc) begin d = ME; s = 1'b1; end
                else if (hlt) d = MH;
                else d = MF;
            end else begin
                d = ME;
            end
        end else begin
            if (hlt) d = MH;
            else if (iip) d = MF;
            else if (intc) begin d = ME; s = 1'b1; end
            else d = MF;
        end
    endfunction

    // DUT sits at phase 0 of m_maj; inputs are held for the whole major cycle
    task automatic run_cycle(input string tag, input logic [11:0] ins, input bit hlt, input bit uf,
                             input bit ir, input bit ie, input bit ih, input bit trg, input bit brk,
                             input bit cnt, input bit ss, input bit si, input int hold_n);
        logic [7:0] exp_q[$];
        int  m, d, nxt, nh;
        bit  s, stalling, nxt_iip;
        m = m_maj;
        s = 1'b0;
        bus.instruction  = ins;
        bus.halt         = hlt;
        bus.UF           = uf;
        bus.int_req      = ir;
        bus.int_ena      = ie;
        bus.int_inh      = ih;
        bus.trigger      = trg;
        bus.brk_req      = brk;
        bus.single_step  = ss;
        bus.single_instr = si;
        stalling = (m == MF || m == MD || m == ME) && (ss || (m == MF && si));
        nh = stalling ? hold_n : 0;
        if (m == MH) begin
            bus.cont = cnt;
            exp_q.push_back(pk(MH, 1, 1'b0, m_iip, 1'b0));
            if (cnt) begin
                nxt = MF;
            end else begin
                if (trg) begin
                    exp_q.push_back(pk(MH, 2, 1'b0, m_iip, 1'b0));
                    exp_q.push_back(pk(MH, 3, 1'b0, m_iip, 1'b0));
                end
                nxt = MH;
            end
            nxt_iip = (nxt == MF) ? 1'b0 : m_iip;
        end else begin
            bus.cont = (nh > 0) ? 1'b0 : 1'b1;
            repeat (nh) exp_q.push_back(pk(m, 0, 1'b0, m_iip, 1'b0));
            repeat (WS) exp_q.push_back(pk(m, 0, 1'b1, m_iip, 1'b0));
            for (int p = 1; p < 4; p++)
                exp_q.push_back(pk(m, p, 1'b0, m_iip, (p == 3) && (m == MB)));
            if (m == MB) begin
                if (brk) nxt = MB;
                else begin nxt = m_pdest; s = m_pset; end
            end else begin
                ref_decide(m, ins, hlt, uf, ir && ie && !ih, m_iip, d, s);
                if (BRK_EN && brk) begin
                    m_pdest = d;
                    m_pset  = s;
                    nxt     = MB;
                    s       = 1'b0;
                end else begin
                    nxt = d;
                end
            end
            if (nxt == MB) nxt_iip = m_iip;
            else if (nxt == MF) nxt_iip = 1'b0;
            else nxt_iip = m_iip | s;
        end
        exp_q.push_back(pk(nxt, 0, 1'b0, nxt_iip, 1'b0));
        foreach (exp_q[i]) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s[%0d]", tag, i), {24'd0, obs()}, {24'd0, exp_q[i]});
            if (nh > 0 && i == nh - 1) bus.cont = 1'b1;
        end
        m_maj = nxt;
        m_iip = nxt_iip;
    endtask

    task automatic reset_mid_wait();
        if (m_maj == MH)
            run_cycle("to_f", 12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        bus.single_step  = 1'b0;
        bus.single_instr = 1'b0;
        bus.brk_req      = 1'b0;
        bus.cont         = 1'b1;
        @(posedge clk);
        #1;
        check_val("in_wait_before_rst", {24'd0, obs()}, {24'd0, pk(m_maj, 0, 1'b1, m_iip, 1'b0)});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_wait", {24'd0, obs()}, {24'd0, pk(MH, 0, 1'b0, 1'b0, 1'b0)});
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset            = 1'b1;
        bus.halt         = 1'b0;
        bus.single_step  = 1'b0;
        bus.single_instr = 1'b0;
        bus.cont         = 1'b0;
        bus.int_req      = 1'b0;
        bus.int_ena      = 1'b0;
        bus.int_inh      = 1'b0;
        bus.UF           = 1'b0;
        bus.trigger      = 1'b0;
        bus.brk_req      = 1'b0;
        bus.instruction  = 12'o0000;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset", {24'd0, obs()}, {24'd0, pk(MH, 0, 1'b0, 1'b0, 1'b0)});
        reset = 1'b0;
        model_reset();

        //        tag        ins       hlt uf ir ie ih trg brk cnt ss si hold
        run_cycle("hw_cont",  12'o0000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("tad_f",    12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("tad_e",    12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("hlt_uf0",  12'o7402, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("h_trig",   12'o7402, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_cycle("h_idle",   12'o7402, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("h_cont",   12'o7402, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("hlt_uf1",  12'o7402, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("iot6002",  12'o6002, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("int_f",    12'o7000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("int_e",    12'o7000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("jmpi_f",   12'o5634, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("jmpi_d",   12'o5634, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        run_cycle("brk_b1",   12'o5634, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        run_cycle("brk_b2",   12'o5634, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("ss_f",     12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle("ss_e",     12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4);
        run_cycle("si_f",     12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        run_cycle("si_e",     12'o1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        reset_mid_wait();

        for (int k = 0; k < 400; k++) begin
            logic [11:0] ins;
            case ($urandom_range(0, 7))
                0:       ins = 12'o6002;
                1:       ins = 12'o7400 | 12'($urandom_range(0, 255));
                2:       ins = 12'o5000 | 12'($urandom_range(0, 511));
                default: ins = 12'($urandom_range(0, 4095));
            endcase
            run_cycle("rnd", ins, rb(6), rb(2), rb(2), rb(2), rb(3), rb(2), rb(5), rb(2),
                      rb(8), rb(8), $urandom_range(0, 3));
            if (k == 200) reset_mid_wait();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
